bist_controller: RTL and testbench

BIST_CONTROLLER -- requirements
Module: bist_controller

---
 rtl/bist_pkg.sv | 22 ++
 rtl/misr3.sv | 30 +++
 rtl/bist_controller.sv | 118 +++++++++++
 tb/tb_bist_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the 3-bit LFSR/MISR built-in self-test controller.
package bist_pkg;

    localparam int W = 3;

    // Feedback taps select bits 3 and 1 into the new bit 1.
    localparam logic [W:1] LFSR_TAPS     = 3'b101;
    localparam logic [W:1] SEED_FALLBACK = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [W:1] lfsr_next(input logic [W:1] p);
        return {p[2], p[1], ^(p & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/misr3.sv
// Three-bit multiple-input signature register compacting the circuit responses.
module misr3
    import bist_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [W:1] d,
    input  logic       clear,
    output logic [W:1] q
);

    logic [W:1] sig_q;
    logic [W:1] sig_d;

    assign sig_d = lfsr_next(sig_q) ^ d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sig_q <= '0;
        end else if (clear) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= sig_d;
        end
    end

    assign q = sig_q;

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: seeds the LFSR, streams N_PATTERNS patterns, compacts responses, reports pass.
// States: IDLE wait | SEED load | RUN stream | DRAIN last response | DONE report.
module bist_controller
    import bist_pkg::*;
#(
    parameter int unsigned N_PATTERNS = 7,
    parameter logic [W:1]  SEED       = 3'b001,
    parameter logic [W:1]  GOLDEN_SIG = 3'b100
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       abort,
    output logic [W:1] pat_out,
    output logic       pat_valid,
    input  logic [W:1] dut_resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [W:1] signature
);

    localparam logic [W:1] SEED_INIT = (SEED == '0) ? SEED_FALLBACK : SEED;
    localparam logic [7:0] LAST_CNT  = 8'(N_PATTERNS - 1);

    state_e     state_q;
    logic [W:1] lfsr_q;
    logic [W:1] lfsr_d;
    logic [7:0] count_q;
    logic       pat_valid_q;
    logic       resp_valid_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [W:1] sig_q;
    logic [W:1] misr_q;
    logic       in_session;

    assign lfsr_d     = lfsr_next(lfsr_q);
    assign in_session = (state_q == ST_SEED) || (state_q == ST_RUN) || (state_q == ST_DRAIN);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= SEED_FALLBACK;
            count_q      <= '0;
            pat_valid_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            sig_q        <= '0;
        end else begin
            resp_valid_q <= pat_valid_q;
            done_q       <= 1'b0;
            if (abort && in_session) begin
                state_q     <= ST_IDLE;
                pat_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                pass_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            state_q <= ST_SEED;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_SEED: begin
                        lfsr_q      <= SEED_INIT;
                        count_q     <= '0;
                        pass_q      <= 1'b0;
                        pat_valid_q <= 1'b1;
                        state_q     <= ST_RUN;
                    end
                    // The LFSR doubles as the pattern register, so it freezes on the last pattern.
                    ST_RUN: begin
                        if (count_q == LAST_CNT) begin
                            pat_valid_q <= 1'b0;
                            state_q     <= ST_DRAIN;
                        end else begin
                            lfsr_q  <= lfsr_d;
                            count_q <= count_q + 8'd1;
                        end
                    end
                    ST_DRAIN: begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                    ST_DONE: begin
                        sig_q   <= misr_q;
                        pass_q  <= (misr_q == GOLDEN_SIG);
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    misr3 u_misr (
        .clk   (clk),
        .clr   (clr),
        .en    (resp_valid_q),
        .d     (dut_resp),
        .clear (state_q == ST_SEED),
        .q     (misr_q)
    );

    assign pat_out   = lfsr_q;
    assign pat_valid = pat_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: default instance and a 10-pattern, zero-seed instance side by side.
module tb_bist_controller;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:1] resp_w      [2];
    logic [3:1] pat_out_w   [2];
    logic       pat_valid_w [2];
    logic       busy_w      [2];
    logic       done_w      [2];
    logic       pass_w      [2];
    logic [3:1] sig_w       [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bist_controller u_dut0 (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .pat_out(pat_out_w[0]), .pat_valid(pat_valid_w[0]), .dut_resp(resp_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .signature(sig_w[0])
    );

    bist_controller #(.N_PATTERNS(10), .SEED(3'b000), .GOLDEN_SIG(3'b100)) u_dut1 (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .pat_out(pat_out_w[1]), .pat_valid(pat_valid_w[1]), .dut_resp(resp_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .signature(sig_w[1])
    );

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[dut%0d] actual=%0d expected=%0d t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model: session timeline by cycle offset ----------------
    int         np [2] = '{7, 10};
    logic [3:1] seqlit [7] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100};
    logic [3:1] gold = 3'b100;

    // ph: 0 idle, 1 seed cycle, 2..n+1 pattern cycles, n+2 drain, n+3 done
    int         ph       [2] = '{0, 0};
    logic [3:1] pat_last [2] = '{3'b001, 3'b001};
    logic [3:1] misr_m   [2] = '{3'b000, 3'b000};
    logic       pvp      [2] = '{1'b0, 1'b0};
    logic       pass_m   [2] = '{1'b0, 1'b0};
    logic [3:1] sig_m    [2] = '{3'b000, 3'b000};

    function automatic logic [3:1] shift3(input logic [3:1] s);
        return {s[2], s[1], s[3] ^ s[1]};
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int k = 0; k < 2; k++) begin
                ph[k] = 0; pat_last[k] = 3'b001; misr_m[k] = '0;
                pvp[k] = 1'b0; pass_m[k] = 1'b0; sig_m[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int   n;
                logic pv_now;
                n = np[k];
                pv_now = (ph[k] >= 2) && (ph[k] <= n + 1);
                if (ph[k] == n + 3) begin
                    sig_m[k]  = misr_m[k];
                    pass_m[k] = (misr_m[k] == gold);
                end
                if (ph[k] == 1) misr_m[k] = '0;
                else if (pvp[k]) misr_m[k] = shift3(misr_m[k]) ^ resp_w[k];
                pvp[k] = pv_now;
                if (ph[k] == 0) begin
                    if (start && !abort) ph[k] = 1;
                end else if (abort && ph[k] <= n + 2) begin
                    ph[k] = 0;
                    pass_m[k] = 1'b0;
                end else if (ph[k] == 1) begin
                    pass_m[k] = 1'b0;
                    ph[k] = 2;
                end else if (ph[k] == n + 3) begin
                    ph[k] = 0;
                end else begin
                    ph[k] = ph[k] + 1;
                end
                if (ph[k] >= 2 && ph[k] <= n + 1) pat_last[k] = seqlit[(ph[k] - 2) % 7];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                int n;
                n = np[k];
                chk("pat_valid", k, int'(pat_valid_w[k]), int'(ph[k] >= 2 && ph[k] <= n + 1));
                chk("busy",      k, int'(busy_w[k]),      int'(ph[k] >= 1 && ph[k] <= n + 2));
                chk("done",      k, int'(done_w[k]),      int'(ph[k] == n + 3));
                chk("pat_out",   k, int'(pat_out_w[k]),   int'(pat_last[k]));
                chk("pass",      k, int'(pass_w[k]),      int'(pass_m[k]));
                chk("signature", k, int'(sig_w[k]),       int'(sig_m[k]));
            end
        end
    end

    // ---------------- response drivers and observers ----------------
    logic [1:0] mode     [2] = '{2'd0, 2'd0};   // 0 loopback, 1 zero, 2 random
    logic [3:1] last_pat [2] = '{3'b000, 3'b000};
    int         edge_n = 0;
    int         start_edge = 0;
    int         done_cnt  [2] = '{0, 0};
    int         done_edge [2] = '{0, 0};
    logic [3:1] obs0 [$];
    logic [3:1] obs1 [$];

    always @(posedge clk) edge_n++;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            last_pat[k] = pat_out_w[k];
            if (done_w[k]) begin
                done_cnt[k]++;
                done_edge[k] = edge_n;
            end
        end
        if (pat_valid_w[0]) obs0.push_back(pat_out_w[0]);
        if (pat_valid_w[1]) obs1.push_back(pat_out_w[1]);
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            case (mode[k])
                2'd0:    resp_w[k] = last_pat[k];
                2'd1:    resp_w[k] = 3'b000;
                default: resp_w[k] = 3'($urandom_range(7, 0));
            endcase
        end
    end

    task automatic clear_obs();
        obs0.delete();
        obs1.delete();
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start_edge = edge_n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_literals(input int k);
        chk("rst_pat_out",   k, int'(pat_out_w[k]),   1);
        chk("rst_pat_valid", k, int'(pat_valid_w[k]), 0);
        chk("rst_busy",      k, int'(busy_w[k]),      0);
        chk("rst_done",      k, int'(done_w[k]),      0);
        chk("rst_pass",      k, int'(pass_w[k]),      0);
        chk("rst_signature", k, int'(sig_w[k]),       0);
    endtask

    initial begin
        logic [3:1] exp_seq [7];
        exp_seq = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100};
        resp_w[0] = '0;
        resp_w[1] = '0;

        #1 clr = 1'b1;
        #1;
        check_reset_literals(0);
        check_reset_literals(1);
        idle(3);
        clr = 1'b0;
        cmp_en = 1'b1;

        // loopback session: literal pattern list, latency and golden signature
        clear_obs();
        pulse_start();
        idle(16);
        chk("lb_npat", 0, obs0.size(), 7);
        for (int i = 0; i < 7 && i < obs0.size(); i++) chk("lb_pat", 0, int'(obs0[i]), int'(exp_seq[i]));
        chk("lb_done_cnt", 0, done_cnt[0], 1);
        chk("lb_done_lat", 0, done_edge[0] - start_edge, 9);
        chk("lb_sig", 0, int'(sig_w[0]), 4);
        chk("lb_pass", 0, int'(pass_w[0]), 1);
        chk("wrap_npat", 1, obs1.size(), 10);
        if (obs1.size() == 10) begin
            chk("wrap_p8",  1, int'(obs1[7]), 1);
            chk("wrap_p9",  1, int'(obs1[8]), 3);
            chk("wrap_p10", 1, int'(obs1[9]), 7);
        end
        chk("wrap_done_lat", 1, done_edge[1] - start_edge, 12);

        // abort during the 4th pattern cycle, then a clean full session
        clear_obs();
        pulse_start();
        idle(4);
        chk("ab_in_run", 0, int'(pat_valid_w[0]), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_pat_valid", 0, int'(pat_valid_w[0]), 0);
        chk("ab_busy", 0, int'(busy_w[0]), 0);
        chk("ab_pass", 0, int'(pass_w[0]), 0);
        chk("ab_sig_held", 0, int'(sig_w[0]), 4);
        idle(15);
        chk("ab_no_done", 0, done_cnt[0], 0);
        clear_obs();
        pulse_start();
        idle(16);
        chk("ab_rerun_npat", 0, obs0.size(), 7);
        chk("ab_rerun_sig", 0, int'(sig_w[0]), 4);
        chk("ab_rerun_pass", 0, int'(pass_w[0]), 1);

        // zero response
        mode[0] = 2'd1;
        mode[1] = 2'd1;
        clear_obs();
        pulse_start();
        idle(16);
        chk("zero_sig", 0, int'(sig_w[0]), 0);
        chk("zero_pass", 0, int'(pass_w[0]), 0);
        chk("zero_done_cnt", 0, done_cnt[0], 1);
        mode[0] = 2'd0;
        mode[1] = 2'd0;

        // start held across a whole session, dropped just before dut0 could restart
        clear_obs();
        @(negedge clk);
        start = 1'b1;
        repeat (11) @(negedge clk);
        start = 1'b0;
        idle(15);
        chk("hold_done_cnt", 0, done_cnt[0], 1);
        chk("hold_done_cnt", 1, done_cnt[1], 1);
        chk("hold_sig", 0, int'(sig_w[0]), 4);

        // asynchronous clear between edges mid-run
        clear_obs();
        pulse_start();
        idle(3);
        #2 clr = 1'b1;
        #1;
        check_reset_literals(0);
        @(negedge clk);
        clr = 1'b0;
        idle(15);
        chk("clr_no_done", 0, done_cnt[0], 0);
        chk("clr_no_done", 1, done_cnt[1], 0);

        // randomized traffic against the model
        mode[0] = 2'd2;
        mode[1] = 2'd2;
        clear_obs();
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(7, 0) == 0);
            abort = ($urandom_range(23, 0) == 0);
            if ($urandom_range(399, 0) == 0) begin
                #2 clr = 1'b1;
                #2 clr = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        idle(16);
        chk("rand_sessions_seen", 0, int'(done_cnt[0] > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
